// File: rtl/write_dest_pipe.sv
// rtl/write_dest_pipe.sv - destination select, EX/MEM and MEM/WB destination pipe, forwarding compare (optional counter: WRITE_DEST_FWD_CNT_EN)
module write_dest_pipe #(
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [1:0]        reg_dst,
    input  logic              reg_write,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    output logic [ADDR_W-1:0] dest_comb,
    output logic [ADDR_W-1:0] mem_dest,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] wb_dest,
    output logic              wb_wr,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [15:0]       fwd_cnt
);

    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    logic ex_wr;

    // Destination mux; the reserved encoding selects register 0 so it can never write
    always_comb begin
        dest_comb = '0;
        case (reg_dst)
            2'b00:   dest_comb = rt;
            2'b01:   dest_comb = rd;
            2'b10:   dest_comb = LINK_ADDR;
            default: dest_comb = '0;
        endcase
    end

    // Writes to register 0 are dropped here so the forwarding compare never matches src=0
    assign ex_wr = in_valid & reg_write & (reg_dst != 2'b11) & (dest_comb != '0);

    // Two-stage destination pipe: flush bubbles MEM even under stall, WB only moves when not stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_dest <= '0;
            mem_wr   <= 1'b0;
            wb_dest  <= '0;
            wb_wr    <= 1'b0;
        end else begin
            if (flush) begin
                mem_dest <= '0;
                mem_wr   <= 1'b0;
            end else if (!stall) begin
                mem_dest <= dest_comb;
                mem_wr   <= ex_wr;
            end
            if (!stall) begin
                wb_dest <= mem_dest;
                wb_wr   <= mem_wr;
            end
        end
    end

    // Forward selects: the younger MEM result wins over WB when both match
    always_comb begin
        fwd_a = FWD_NONE;
        fwd_b = FWD_NONE;
        if (mem_wr && (mem_dest == src_a)) begin
            fwd_a = FWD_MEM;
        end else if (wb_wr && (wb_dest == src_a)) begin
            fwd_a = FWD_WB;
        end
        if (mem_wr && (mem_dest == src_b)) begin
            fwd_b = FWD_MEM;
        end else if (wb_wr && (wb_dest == src_b)) begin
            fwd_b = FWD_WB;
        end
    end

`ifdef WRITE_DEST_FWD_CNT_EN
    logic [15:0] cnt_q;
    logic        fwd_event;

    assign fwd_event = !stall && ((fwd_a != FWD_NONE) || (fwd_b != FWD_NONE));

    // Saturating count of forwarding events on non-stalled edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (fwd_event && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign fwd_cnt = cnt_q;
`else
    assign fwd_cnt = '0;
`endif

endmodule
